// File: rtl/axi4_lite_read_arbiter_pkg.sv
// Shared types for the AXI4-Lite read arbiter: the arbiter FSM state encoding.
package axi4_lite_read_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/axi4_lite_read_arbiter_if.sv
// Bundle of the requester-side ports and the read-master handshake around the read arbiter.
interface axi4_lite_read_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic [IDX_W-1:0]              grant_id;
    logic                          arb_busy;
    logic                          read_start;
    logic [ADDR_WIDTH-1:0]         read_addr;
    logic                          rm_busy;
    logic [DATA_WIDTH-1:0]         rm_rdata;

    // The arbiter serves requests, so it takes the slave view.
    modport slave (
        input  req_valid, req_addr, rm_busy, rm_rdata,
        output req_ready, resp_valid, resp_data, grant_id, arb_busy, read_start, read_addr
    );

    modport master (
        output req_valid, req_addr, rm_busy, rm_rdata,
        input  req_ready, resp_valid, resp_data, grant_id, arb_busy, read_start, read_addr
    );

endinterface

// File: rtl/axi4_lite_read_arbiter_rr.sv
// Combinational round-robin picker: lowest index after 'last' (wrapping) with req set wins.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]                        req,
    input  logic [((N > 1) ? $clog2(N) : 1)-1:0] last,
    output logic [N-1:0]                        grant,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
    output logic                                any
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int i = 1; i <= N; i++) begin
            if (!any && req[(int'(last) + i) % N]) begin
                any                          = 1'b1;
                grant[(int'(last) + i) % N]  = 1'b1;
                grant_idx                    = IW'((int'(last) + i) % N);
            end
        end
    end

endmodule

// File: rtl/axi4_lite_read_arbiter.sv
// Shares one AXI4-Lite read master between NUM_REQ requesters, round-robin,
// with a single outstanding read sequenced through the master's read_start/busy handshake.
module axi4_lite_read_arbiter
    import axi4_lite_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    axi4_lite_read_arbiter_if.slave   bus
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        last_q;
    logic [IDX_W-1:0]        grant_id_q;
    logic [ADDR_WIDTH-1:0]   addr_buf_q;
    logic [DATA_WIDTH-1:0]   resp_data_q;

    logic [NUM_REQ-1:0]      win_onehot;
    logic [IDX_W-1:0]        win_idx;
    logic                    win_any;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req       (bus.req_valid),
        .last      (last_q),
        .grant     (win_onehot),
        .grant_idx (win_idx),
        .any       (win_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= IDX_W'(NUM_REQ - 1);
            grant_id_q  <= '0;
            addr_buf_q  <= '0;
            resp_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && win_any) begin
                addr_buf_q <= bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
                grant_id_q <= win_idx;
                last_q     <= win_idx;
            end
            if (state_q == WAIT && !bus.rm_busy) begin
                resp_data_q <= bus.rm_rdata;
            end
        end
    end

    // req_ready is combinational in IDLE so the accept lands in the same cycle as the pick.
    always_comb begin
        state_d        = state_q;
        bus.req_ready  = '0;
        bus.resp_valid = '0;
        bus.read_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_any) begin
                    bus.req_ready = win_onehot;
                    state_d       = ISSUE;
                end
            end
            ISSUE: begin
                bus.read_start = 1'b1;
                state_d        = WAIT;
            end
            WAIT: begin
                if (!bus.rm_busy) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.resp_valid[grant_id_q] = 1'b1;
                state_d                    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.read_addr = addr_buf_q;
    assign bus.resp_data = resp_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.arb_busy  = (state_q != IDLE);

    // The master was idle when we started it, so it must report busy on the first WAIT cycle.
    first_wait_busy: assert property (@(posedge clk) disable iff (rst)
        (state_q == WAIT && $past(state_q) == ISSUE) |-> bus.rm_busy);

endmodule

// File: tb/tb_axi4_lite_read_arbiter.sv
// Directed bench for the read arbiter with a behavioural read master + slave (configurable AR/R waits).
module tb_axi4_lite_read_arbiter;

    localparam int NUM_REQ = 2;
    localparam int AW      = 32;
    localparam int DW      = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_read_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

    axi4_lite_read_arbiter #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int ar_delay = 0;
    int r_delay  = 0;
    logic [NUM_REQ-1:0] keep_mask = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] slave_data(input logic [AW-1:0] addr);
        return (addr == 32'h0000_1000) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | addr);
    endfunction

    // Read master + slave: busy spans AR (1+ar_delay) and R (1+r_delay) cycles after the start pulse.
    int busy_cnt;
    logic [AW-1:0] lat_addr;
    always @(posedge clk) begin
        if (rst) begin
            ifc.rm_busy  <= 1'b0;
            ifc.rm_rdata <= '0;
            busy_cnt     <= 0;
        end else if (ifc.read_start) begin
            ifc.rm_busy <= 1'b1;
            busy_cnt    <= 1 + ar_delay + r_delay;
            lat_addr    <= ifc.read_addr;
        end else if (ifc.rm_busy) begin
            if (busy_cnt == 0) begin
                ifc.rm_busy  <= 1'b0;
                ifc.rm_rdata <= slave_data(lat_addr);
            end else begin
                busy_cnt <= busy_cnt - 1;
            end
        end
    end

    int          acc_cyc[$];
    int          acc_id[$];
    int          resp_cyc[$];
    int          resp_id[$];
    logic [31:0] resp_dat[$];
    int          rs_cyc[$];
    bit          multihot = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(ifc.req_ready) > 1 || $countones(ifc.resp_valid) > 1) multihot = 1'b1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (ifc.req_ready[i]) begin
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(i);
                end
                if (ifc.resp_valid[i]) begin
                    resp_cyc.push_back(cyc);
                    resp_id.push_back(i);
                    resp_dat.push_back(ifc.resp_data);
                end
            end
            if (ifc.read_start) rs_cyc.push_back(cyc);
        end
    end

    // One cycle; returns 1 time unit after the rising edge. Accepted requesters drop unless kept.
    task automatic tick();
        logic [NUM_REQ-1:0] seen;
        @(negedge clk);
        seen = ifc.req_ready;
        @(posedge clk);
        #1;
        ifc.req_valid = ifc.req_valid & ~(seen & ~keep_mask);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_resp(input int n, input int budget, output bit ok);
        int k = 0;
        while (resp_id.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (resp_id.size() >= n);
    endtask

    task automatic wait_acc(input int n, input int budget, output bit ok);
        int k = 0;
        while (acc_id.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (acc_id.size() >= n);
    endtask

    task automatic wait_rs(input int n, input int budget, output bit ok);
        int k = 0;
        while (rs_cyc.size() < n && k < budget) begin
            tick();
            k++;
        end
        ok = (rs_cyc.size() >= n);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ifc.req_ready, ifc.resp_valid, ifc.read_start, ifc.arb_busy} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0",
                     {ifc.req_ready, ifc.resp_valid, ifc.read_start, ifc.arb_busy});
        end
        checks++;
        if (ifc.resp_data !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_resp_data: got %h expected 00000000", ifc.resp_data);
        end
        checks++;
        if (ifc.read_addr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_read_addr: got %h expected 00000000", ifc.read_addr);
        end
        checks++;
        if (ifc.grant_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_grant_id: got %0d expected 0", ifc.grant_id);
        end
    endtask

    task automatic test_single_read();
        int a0 = acc_id.size();
        int r0 = resp_id.size();
        int s0 = rs_cyc.size();
        bit ok;
        keep_mask     = 2'b00;
        ifc.req_addr  = {32'h0, 32'h0000_1000};
        ifc.req_valid = 2'b01;
        wait_resp(r0 + 1, 30, ok);
        tick();
        tick();
        checks++;
        if (!ok || acc_id.size() <= a0 || rs_cyc.size() <= s0) begin
            errors++;
            $display("[TB] FAIL single_timeout: got %0d responses expected 1", resp_id.size() - r0);
            return;
        end
        checks++;
        if (acc_id[a0] !== 0) begin
            errors++;
            $display("[TB] FAIL single_accept_id: got %0d expected 0", acc_id[a0]);
        end
        checks++;
        if (rs_cyc[s0] - acc_cyc[a0] !== 1) begin
            errors++;
            $display("[TB] FAIL single_start_lat: got %0d expected 1", rs_cyc[s0] - acc_cyc[a0]);
        end
        checks++;
        if (resp_cyc[r0] - acc_cyc[a0] !== 5) begin
            errors++;
            $display("[TB] FAIL single_resp_lat: got %0d expected 5", resp_cyc[r0] - acc_cyc[a0]);
        end
        checks++;
        if (resp_id[r0] !== 0 || resp_dat[r0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL single_resp: got id %0d data %h expected id 0 data deadbeef",
                     resp_id[r0], resp_dat[r0]);
        end
        checks++;
        if (ifc.resp_data !== 32'hDEAD_BEEF || ifc.arb_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL single_hold: got data %h busy %b expected deadbeef 0",
                     ifc.resp_data, ifc.arb_busy);
        end
    endtask

    task automatic test_contention();
        int a0, r0;
        bit ok;
        logic [31:0] exp_data;
        do_reset();
        a0 = acc_id.size();
        r0 = resp_id.size();
        keep_mask     = 2'b11;
        ifc.req_addr  = {32'h0000_0200, 32'h0000_0100};
        ifc.req_valid = 2'b11;
        wait_resp(r0 + 4, 60, ok);
        ifc.req_valid = 2'b00;
        keep_mask     = 2'b00;
        tick();
        tick();
        checks++;
        if (!ok || acc_id.size() - a0 !== 4) begin
            errors++;
            $display("[TB] FAIL contention_count: got %0d accepts expected 4", acc_id.size() - a0);
            return;
        end
        for (int k = 0; k < 4; k++) begin
            exp_data = (k % 2 == 1) ? 32'hC0DE_0200 : 32'hC0DE_0100;
            checks++;
            if (acc_id[a0+k] !== k % 2 || resp_id[r0+k] !== k % 2) begin
                errors++;
                $display("[TB] FAIL contention_order[%0d]: got acc %0d resp %0d expected %0d",
                         k, acc_id[a0+k], resp_id[r0+k], k % 2);
            end
            checks++;
            if (resp_dat[r0+k] !== exp_data) begin
                errors++;
                $display("[TB] FAIL contention_data[%0d]: got %h expected %h", k, resp_dat[r0+k], exp_data);
            end
            if (k > 0) begin
                checks++;
                if (acc_cyc[a0+k] !== resp_cyc[r0+k-1] + 1) begin
                    errors++;
                    $display("[TB] FAIL contention_gap[%0d]: got accept %0d expected %0d",
                             k, acc_cyc[a0+k], resp_cyc[r0+k-1] + 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        int a0 = acc_id.size();
        int r0 = resp_id.size();
        int s0 = rs_cyc.size();
        bit ok;
        ar_delay      = 3;
        r_delay       = 4;
        keep_mask     = 2'b00;
        ifc.req_addr  = {32'h0000_0300, 32'h0};
        ifc.req_valid = 2'b10;
        wait_resp(r0 + 1, 40, ok);
        repeat (4) tick();
        ar_delay = 0;
        r_delay  = 0;
        checks++;
        if (!ok || resp_id.size() - r0 !== 1 || acc_id.size() - a0 !== 1) begin
            errors++;
            $display("[TB] FAIL stall_count: got %0d responses expected 1", resp_id.size() - r0);
            return;
        end
        checks++;
        if (rs_cyc.size() - s0 !== 1) begin
            errors++;
            $display("[TB] FAIL stall_starts: got %0d expected 1", rs_cyc.size() - s0);
        end
        checks++;
        if (resp_cyc[r0] - acc_cyc[a0] !== 12) begin
            errors++;
            $display("[TB] FAIL stall_latency: got %0d expected 12", resp_cyc[r0] - acc_cyc[a0]);
        end
        checks++;
        if (resp_id[r0] !== 1 || resp_dat[r0] !== 32'hC0DE_0300) begin
            errors++;
            $display("[TB] FAIL stall_resp: got id %0d data %h expected id 1 data c0de0300",
                     resp_id[r0], resp_dat[r0]);
        end
    endtask

    task automatic test_starvation();
        int a0, r0;
        bit ok;
        do_reset();
        a0 = acc_id.size();
        r0 = resp_id.size();
        keep_mask     = 2'b01;
        ifc.req_addr  = {32'h0000_0200, 32'h0000_0100};
        ifc.req_valid = 2'b01;
        wait_acc(a0 + 1, 10, ok);
        ifc.req_valid = ifc.req_valid | 2'b10;
        if (ok) wait_resp(r0 + 2, 40, ok);
        ifc.req_valid = 2'b00;
        keep_mask     = 2'b00;
        tick();
        checks++;
        if (!ok || acc_id.size() - a0 !== 2) begin
            errors++;
            $display("[TB] FAIL starve_count: got %0d accepts expected 2", acc_id.size() - a0);
            return;
        end
        checks++;
        if (acc_id[a0] !== 0 || acc_id[a0+1] !== 1) begin
            errors++;
            $display("[TB] FAIL starve_order: got %0d,%0d expected 0,1", acc_id[a0], acc_id[a0+1]);
        end
        checks++;
        if (resp_dat[r0+1] !== 32'hC0DE_0200) begin
            errors++;
            $display("[TB] FAIL starve_data: got %h expected c0de0200", resp_dat[r0+1]);
        end
    endtask

    task automatic test_reset_in_wait();
        int a0 = acc_id.size();
        int r0 = resp_id.size();
        int s0 = rs_cyc.size();
        bit ok;
        ar_delay      = 3;
        keep_mask     = 2'b00;
        ifc.req_addr  = {32'h0000_0200, 32'h0000_1000};
        ifc.req_valid = 2'b10;
        wait_rs(s0 + 1, 10, ok);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (!ok || {ifc.req_ready, ifc.resp_valid, ifc.read_start, ifc.arb_busy} !== '0) begin
            errors++;
            $display("[TB] FAIL rstwait_ctrl: got %b expected 0",
                     {ifc.req_ready, ifc.resp_valid, ifc.read_start, ifc.arb_busy});
        end
        checks++;
        if (ifc.resp_data !== 32'h0 || ifc.read_addr !== 32'h0 || ifc.grant_id !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstwait_regs: got data %h addr %h gid %0d expected 0 0 0",
                     ifc.resp_data, ifc.read_addr, ifc.grant_id);
        end
        ar_delay = 0;
        repeat (12) tick();
        checks++;
        if (resp_id.size() !== r0) begin
            errors++;
            $display("[TB] FAIL rstwait_no_resp: got %0d responses expected 0", resp_id.size() - r0);
        end
        ifc.req_valid = 2'b11;
        wait_resp(r0 + 2, 40, ok);
        tick();
        checks++;
        if (!ok || acc_id.size() - a0 !== 3) begin
            errors++;
            $display("[TB] FAIL rstwait_after: got %0d accepts expected 3", acc_id.size() - a0);
            return;
        end
        checks++;
        if (acc_id[a0+1] !== 0 || resp_id[r0] !== 0 || resp_dat[r0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("[TB] FAIL rstwait_first: got acc %0d resp %0d data %h expected 0 0 deadbeef",
                     acc_id[a0+1], resp_id[r0], resp_dat[r0]);
        end
    endtask

    task automatic test_withdrawn();
        int a0 = acc_id.size();
        int r0 = resp_id.size();
        int s0 = rs_cyc.size();
        bit ok;
        keep_mask     = 2'b00;
        ifc.req_addr  = {32'h0000_0200, 32'h0000_0100};
        ifc.req_valid = 2'b01;
        wait_rs(s0 + 1, 10, ok);
        ifc.req_valid = ifc.req_valid | 2'b10;
        tick();
        ifc.req_valid = ifc.req_valid & 2'b01;
        if (ok) wait_resp(r0 + 1, 30, ok);
        repeat (10) tick();
        checks++;
        if (!ok || acc_id.size() - a0 !== 1 || resp_id.size() - r0 !== 1) begin
            errors++;
            $display("[TB] FAIL withdrawn_count: got %0d accepts %0d responses expected 1 1",
                     acc_id.size() - a0, resp_id.size() - r0);
            return;
        end
        checks++;
        if (acc_id[a0] !== 0 || resp_id[r0] !== 0 || resp_dat[r0] !== 32'hC0DE_0100) begin
            errors++;
            $display("[TB] FAIL withdrawn_resp: got acc %0d resp %0d data %h expected 0 0 c0de0100",
                     acc_id[a0], resp_id[r0], resp_dat[r0]);
        end
        checks++;
        if (rs_cyc.size() - s0 !== 1) begin
            errors++;
            $display("[TB] FAIL withdrawn_starts: got %0d expected 1", rs_cyc.size() - s0);
        end
    endtask

    task automatic test_one_hot();
        checks++;
        if (multihot !== 1'b0) begin
            errors++;
            $display("[TB] FAIL one_hot: got multi-hot %b expected 0", multihot);
        end
    endtask

    initial begin
        ifc.req_valid = '0;
        ifc.req_addr  = '0;
        repeat (3) @(posedge clk);
        #1;
        $display("[TB] starting");
        test_reset();
        test_single_read();
        test_contention();
        test_stall();
        test_starvation();
        test_reset_in_wait();
        test_withdrawn();
        test_one_hot();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
